// File: rtl/upsample_unit_pkg.sv
// Shared definitions for the pooling/upsampling stages of the CNN datapath:
// pixel type, FSM state encoding and a counter-width helper.
package upsample_unit_pkg;

   localparam int PIX_W = 8;

   localparam logic [0:0] ST_FILL   = 1'b0;
   localparam logic [0:0] ST_REPLAY = 1'b1;

   typedef logic [PIX_W-1:0] pix_t;

   // Width of a counter spanning 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/upsample_row_buf.sv
// One pooled row of pixels, captured during FILL and replayed for the second
// output row. Asynchronous read, single write port, no reset on the storage.
module upsample_row_buf
   import upsample_unit_pkg::*;
#(
   parameter int DEPTH = 14,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  pix_t          wr_data,
   input  logic [AW-1:0] rd_addr,
   output pix_t          rd_data
);

   pix_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsample_unit.sv
// Streaming 2x nearest-neighbour upsampler: each pooled pixel is emitted twice
// horizontally, and each pooled row is emitted twice vertically via a row buffer.
module upsample_unit
   import upsample_unit_pkg::*;
#(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  pix_t in_data,
   output logic in_ready,
   output logic out_valid,
   output pix_t out_data,
   input  logic out_ready,
   output logic out_last
);

   localparam int HALF_W = IMG_W / 2;
   localparam int HALF_H = IMG_H / 2;
   localparam int CW     = cnt_w(HALF_W);
   localparam int RW     = cnt_w(HALF_H);
   localparam logic [CW-1:0] COL_LAST = CW'(HALF_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HALF_H - 1);

   logic [0:0]    state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          dup;
   logic          adv;
   logic          in_fire;
   pix_t          rd_data;

   // The output register may be (re)loaded whenever it is empty or being drained.
   assign adv      = !out_valid || out_ready;
   assign in_ready = (state == ST_FILL) && !dup && adv;
   assign in_fire  = in_valid && in_ready;

   upsample_row_buf #(
      .DEPTH (HALF_W),
      .AW    (CW)
   ) u_row_buf (
      .clk     (clk),
      .wr_en   (in_fire),
      .wr_addr (col),
      .wr_data (in_data),
      .rd_addr (col),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FILL;
         col       <= '0;
         row       <= '0;
         dup       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (state == ST_FILL) begin
         if (!dup) begin
            if (in_fire) begin
               out_data  <= in_data;
               out_valid <= 1'b1;
               out_last  <= 1'b0;
               dup       <= 1'b1;
            end else if (adv) begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         end else if (adv) begin
            // Second horizontal copy: out_data already holds the pixel.
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            dup       <= 1'b0;
            if (col == COL_LAST) begin
               col   <= '0;
               state <= ST_REPLAY;
            end else begin
               col <= col + CW'(1);
            end
         end
      end else if (adv) begin
         out_data  <= rd_data;
         out_valid <= 1'b1;
         out_last  <= dup && (col == COL_LAST) && (row == ROW_LAST);
         dup       <= !dup;
         if (dup) begin
            if (col == COL_LAST) begin
               col   <= '0;
               state <= ST_FILL;
               row   <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_upsample_unit.sv
// Self-checking bench for upsample_unit: a 4x4 and a 28x28 instance share the
// stimulus; sel chooses which one is observed and checked.
module tb_upsample_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;
   logic       sel;

   logic       a_in_ready, a_out_valid, a_out_last;
   logic [7:0] a_out_data;
   logic       b_in_ready, b_out_valid, b_out_last;
   logic [7:0] b_out_data;

   logic       s_in_ready, s_out_valid, s_out_last;
   logic [7:0] s_out_data;

   int n_err = 0;
   int n_chk = 0;

   logic [7:0] src[$];
   int got_d[$];
   int got_l[$];
   int inr_hist[$];
   int first_fire;
   int last_out;

   int exp4[16] = '{10, 10, 20, 20, 10, 10, 20, 20, 30, 30, 40, 40, 30, 30, 40, 40};

   always #5 clk = ~clk;

   assign s_in_ready  = sel ? b_in_ready  : a_in_ready;
   assign s_out_valid = sel ? b_out_valid : a_out_valid;
   assign s_out_data  = sel ? b_out_data  : a_out_data;
   assign s_out_last  = sel ? b_out_last  : a_out_last;

   upsample_unit #(.IMG_W(4), .IMG_H(4)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (a_in_ready),
      .out_valid (a_out_valid),
      .out_data  (a_out_data),
      .out_ready (out_ready),
      .out_last  (a_out_last)
   );

   upsample_unit #(.IMG_W(28), .IMG_H(28)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (b_in_ready),
      .out_valid (b_out_valid),
      .out_data  (b_out_data),
      .out_ready (out_ready),
      .out_last  (b_out_last)
   );

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Drives src into the observed instance and collects accepted outputs until
   // stop_after outputs have been seen or max_cyc cycles have elapsed.
   task automatic run(input int gap_pct, input int stall_pct, input int stop_after,
                      input int stall_at, input int stall_len, input int max_cyc);
      int  idx = 0;
      int  cyc = 0;
      int  stall_left = 0;
      bit  stalled_once = 1'b0;
      bit  pv = 1'b0;
      bit  pr = 1'b1;
      int  pd = 0;
      int  pl = 0;
      got_d.delete();
      got_l.delete();
      inr_hist.delete();
      first_fire = -1;
      last_out   = -1;
      while (got_d.size() < stop_after && cyc < max_cyc) begin
         in_valid = (idx < src.size()) && (int'($urandom_range(99)) >= gap_pct);
         in_data  = (idx < src.size()) ? src[idx] : 8'd0;
         if (stall_left > 0) begin
            out_ready  = 1'b0;
            stall_left = stall_left - 1;
         end else if (!stalled_once && stall_len > 0 && got_d.size() == stall_at && s_out_valid) begin
            out_ready    = 1'b0;
            stall_left   = stall_len - 1;
            stalled_once = 1'b1;
         end else begin
            out_ready = (int'($urandom_range(99)) >= stall_pct);
         end
         @(negedge clk);
         inr_hist.push_back(int'(s_in_ready));
         if (pv && !pr) begin
            check("hold_valid", int'(s_out_valid), 1);
            check("hold_data", int'(s_out_data), pd);
            check("hold_last", int'(s_out_last), pl);
         end
         if (in_valid && s_in_ready) begin
            if (first_fire < 0) first_fire = cyc;
            idx++;
         end
         if (s_out_valid && out_ready) begin
            got_d.push_back(int'(s_out_data));
            got_l.push_back(int'(s_out_last));
            last_out = cyc;
         end
         pv = s_out_valid;
         pr = out_ready;
         pd = int'(s_out_data);
         pl = int'(s_out_last);
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("outputs_seen", got_d.size(), stop_after);
   endtask

   task automatic check_fixed4(input string tag);
      check({tag, "_count"}, got_d.size(), 16);
      for (int i = 0; i < 16 && i < got_d.size(); i++) begin
         check($sformatf("%s_d%0d", tag, i), got_d[i], exp4[i]);
         check($sformatf("%s_l%0d", tag, i), got_l[i], (i == 15) ? 1 : 0);
      end
   endtask

   // Reference: out(r,c) of frame f is in(f, r/2, c/2); last marks the frame's final pixel.
   task automatic check_model(input string tag, input int w, input int h);
      int hw = w / 2;
      int hh = h / 2;
      int nf = src.size() / (hw * hh);
      int k  = 0;
      check({tag, "_count"}, got_d.size(), nf * w * h);
      for (int f = 0; f < nf; f++)
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
               if (k < got_d.size()) begin
                  check($sformatf("%s_d%0d", tag, k), got_d[k],
                        int'(src[f * hw * hh + (r / 2) * hw + c / 2]));
                  check($sformatf("%s_l%0d", tag, k), got_l[k],
                        (r == h - 1 && c == w - 1) ? 1 : 0);
               end
               k++;
            end
   endtask

   initial begin
      sel = 1'b0;
      do_reset();
      check("rst_a_valid", int'(a_out_valid), 0);
      check("rst_a_data", int'(a_out_data), 0);
      check("rst_a_last", int'(a_out_last), 0);
      check("rst_a_ready", int'(a_in_ready), 1);
      check("rst_b_valid", int'(b_out_valid), 0);
      check("rst_b_ready", int'(b_in_ready), 1);

      // 4x4 directed frame, free-flowing output
      src = '{8'd10, 8'd20, 8'd30, 8'd40};
      run(0, 0, 16, -1, 0, 200);
      check_fixed4("fix");
      check("fix_cycles", last_out - first_fire, 16);

      // Five-cycle stall on the second copy of 20
      do_reset();
      run(0, 0, 16, 3, 5, 200);
      check_fixed4("stall");

      // Reset while replaying output row 3
      do_reset();
      run(0, 0, 13, -1, 0, 200);
      check("pre_rst_replay_ready", int'(a_in_ready), 0);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_valid", int'(a_out_valid), 0);
      check("midrst_last", int'(a_out_last), 0);
      check("midrst_ready", int'(a_in_ready), 1);
      run(0, 0, 16, -1, 0, 200);
      check_fixed4("after_rst");

      // 28x28, ramp input, two frames back to back
      sel = 1'b1;
      do_reset();
      src.delete();
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < 196; k++) src.push_back(8'(k));
      run(0, 0, 1568, -1, 0, 5000);
      for (int i = 0; i < 1568 && i < got_d.size(); i++) begin
         check($sformatf("ramp_d%0d", i), got_d[i], ((i % 784) / 28 / 2) * 14 + ((i % 28) / 2));
         check($sformatf("ramp_l%0d", i), got_l[i], ((i % 784) == 783) ? 1 : 0);
      end
      check("ramp_cycles", last_out - first_fire, 1568);
      for (int i = 0; i < 112 && i < inr_hist.size(); i++)
         check($sformatf("ramp_rdy%0d", i), inr_hist[i], ((i % 56) < 28 && (i % 2) == 0) ? 1 : 0);

      // Random data, random input gaps and random backpressure on both sizes
      sel = 1'b0;
      do_reset();
      src.delete();
      for (int k = 0; k < 12; k++) src.push_back(8'($urandom));
      run(30, 50, 48, -1, 0, 2000);
      check_model("rnd4", 4, 4);

      sel = 1'b1;
      do_reset();
      src.delete();
      for (int k = 0; k < 392; k++) src.push_back(8'($urandom));
      run(30, 50, 1568, -1, 0, 20000);
      check_model("rnd28", 28, 28);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
